// File: rtl/sa_tile_engine.sv
// Output-stationary ROWS x COLS fixed-point systolic matrix-multiply tile with
// built-in operand skew, counter-driven flush and a row-per-beat result stream.
module sa_tile_engine #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int K_MAX      = 256,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 1,
    localparam int KW = $clog2(K_MAX + 1),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_a,
    input  logic [COLS*DATA_WIDTH-1:0] in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*DATA_WIDTH-1:0] out_data,
    output logic [RW-1:0]              out_row,
    output logic                       out_last,
    output logic                       overflow
);

    localparam int DW         = DATA_WIDTH;
    localparam int ACC_W      = 2 * DW + KW;
    localparam int FLUSH_N    = ROWS + COLS - 2;
    localparam int FLUSH_LAST = (FLUSH_N > 0) ? FLUSH_N - 1 : 0;
    localparam int CNT_W      = $clog2(K_MAX + FLUSH_N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t           state;
    logic [KW-1:0]    k_lat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k_ext;
    logic             accept;
    logic             step;

    logic [DW-1:0]    a_src  [ROWS];
    logic [DW-1:0]    b_src  [COLS];
    logic [DW-1:0]    a_skew [ROWS][ROWS];
    logic [DW-1:0]    b_skew [COLS][COLS];
    logic [DW-1:0]    a_left [ROWS][COLS];
    logic [DW-1:0]    b_top  [ROWS][COLS];
    logic [DW-1:0]    a_reg  [ROWS][COLS];
    logic [DW-1:0]    b_reg  [ROWS][COLS];
    logic [ACC_W-1:0] acc    [ROWS][COLS];

    logic [COLS*DW-1:0] row_data;
    logic               row_ovf;
    logic [DW:0]        conv;

    // Full-width product, rescaled by FRAC_BITS and extended to accumulator width.
    function automatic logic [ACC_W-1:0] scaled_product(input logic [DW-1:0] a,
                                                        input logic [DW-1:0] b);
        logic [2*DW-1:0] a_ext;
        logic [2*DW-1:0] b_ext;
        logic [2*DW-1:0] prod;
        logic [2*DW-1:0] shifted;
        if (SIGNED != 0) begin
            a_ext   = {{DW{a[DW-1]}}, a};
            b_ext   = {{DW{b[DW-1]}}, b};
            prod    = a_ext * b_ext;
            shifted = $unsigned($signed(prod) >>> FRAC_BITS);
            return {{KW{shifted[2*DW-1]}}, shifted};
        end else begin
            a_ext   = {{DW{1'b0}}, a};
            b_ext   = {{DW{1'b0}}, b};
            prod    = a_ext * b_ext;
            shifted = prod >> FRAC_BITS;
            return {{KW{1'b0}}, shifted};
        end
    endfunction

    // Returns {not_representable, converted element}.
    function automatic logic [DW:0] convert(input logic [ACC_W-1:0] v);
        logic          fits;
        logic [DW-1:0] clip;
        if (SIGNED != 0) begin
            fits = (&v[ACC_W-1:DW-1]) || (~|v[ACC_W-1:DW-1]);
            clip = v[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            fits = ~|v[ACC_W-1:DW];
            clip = '1;
        end
        if (fits)
            return {1'b0, v[DW-1:0]};
        else if (SATURATE != 0)
            return {1'b1, clip};
        else
            return {1'b1, v[DW-1:0]};
    endfunction

    assign accept = (state == IDLE) && start;
    assign step   = ((state == LOAD) && in_valid) || (state == FLUSH);
    assign k_ext  = CNT_W'(k_lat);

    // Array edges: zeros are injected outside LOAD, so FLUSH steps push zeros.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            a_src[r] = (state == LOAD) ? in_a[r*DW +: DW] : '0;
        for (int c = 0; c < COLS; c++)
            b_src[c] = (state == LOAD) ? in_b[c*DW +: DW] : '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (c == 0)
                    a_left[r][c] = (r == 0) ? a_src[r] : a_skew[r][(r > 0) ? r - 1 : 0];
                else
                    a_left[r][c] = a_reg[r][(c > 0) ? c - 1 : 0];
                if (r == 0)
                    b_top[r][c] = (c == 0) ? b_src[c] : b_skew[c][(c > 0) ? c - 1 : 0];
                else
                    b_top[r][c] = b_reg[(r > 0) ? r - 1 : 0][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < ROWS; i++) a_skew[r][i] <= '0;
            for (int c = 0; c < COLS; c++)
                for (int i = 0; i < COLS; i++) b_skew[c][i] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
        end else if (accept) begin
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < ROWS; i++) a_skew[r][i] <= '0;
            for (int c = 0; c < COLS; c++)
                for (int i = 0; i < COLS; i++) b_skew[c][i] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
        end else if (step) begin
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < ROWS; i++)
                    a_skew[r][i] <= (i == 0) ? a_src[r] : a_skew[r][(i > 0) ? i - 1 : 0];
            for (int c = 0; c < COLS; c++)
                for (int i = 0; i < COLS; i++)
                    b_skew[c][i] <= (i == 0) ? b_src[c] : b_skew[c][(i > 0) ? i - 1 : 0];
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= a_left[r][c];
                    b_reg[r][c] <= b_top[r][c];
                    acc[r][c]   <= acc[r][c] + scaled_product(a_left[r][c], b_top[r][c]);
                end
        end
    end

    always_comb begin
        row_data = '0;
        row_ovf  = 1'b0;
        conv     = '0;
        for (int c = 0; c < COLS; c++) begin
            conv                = convert(acc[out_row][c]);
            row_data[c*DW +: DW] = conv[DW-1:0];
            row_ovf             = row_ovf | conv[DW];
        end
    end

    assign out_data = out_valid ? row_data : '0;

    // Job sequencing; a single counter covers both the beat count and the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_lat     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k_lat    <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
                    cnt      <= '0;
                    overflow <= 1'b0;
                    busy     <= 1'b1;
                    if (k_len == '0) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_row   <= '0;
                        out_last  <= (ROWS == 1);
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                LOAD: if (in_valid) begin
                    if (cnt == k_ext - CNT_W'(1)) begin
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (FLUSH_N == 0) begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_row   <= '0;
                            out_last  <= (ROWS == 1);
                        end else begin
                            state <= FLUSH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == CNT_W'(FLUSH_LAST)) begin
                        cnt       <= '0;
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_row   <= '0;
                        out_last  <= (ROWS == 1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: if (out_ready) begin
                    overflow <= overflow | row_ovf;
                    if (out_row == RW'(ROWS - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_row   <= '0;
                    end else begin
                        out_row  <= out_row + 1'b1;
                        out_last <= (out_row + 1'b1 == RW'(ROWS - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_tile_engine.sv
// Directed bench for a 2x2, Q8.8 signed, saturating sa_tile_engine with K_MAX=4.
module tb_sa_tile_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  k_len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [0:0]  out_row;
    logic        out_last;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] beat_a [4];
    logic [31:0] beat_b [4];

    sa_tile_engine #(
        .ROWS(2), .COLS(2), .DATA_WIDTH(16), .FRAC_BITS(8),
        .K_MAX(4), .SIGNED(1), .SATURATE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input logic [2:0] k);
        start = 1'b1;
        k_len = k;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_a = beat_a[i];
            in_b = beat_b[i];
            step();
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic set_identity();
        beat_a[0] = 32'h0300_0100;
        beat_a[1] = 32'h0400_0200;
        beat_b[0] = 32'h0000_0100;
        beat_b[1] = 32'h0100_0000;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, in_ready, out_valid, out_last, overflow} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 00000", {busy, in_ready, out_valid, out_last, overflow});
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h want 00000000", out_data);
        end
        checks++;
        if (out_row !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_row: got %0d want 0", out_row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_identity();
        set_identity();
        out_ready = 1'b1;
        begin_job(3'd2);
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL id_start_flags: got %b want 110", {busy, in_ready, out_valid});
        end
        in_valid = 1'b1; in_a = beat_a[0]; in_b = beat_b[0];
        step();
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL id_data_idle: got %h want 00000000", out_data);
        end
        in_a = beat_a[1]; in_b = beat_b[1];
        step();
        in_valid = 1'b0; in_a = '0; in_b = '0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL id_ready_after_k: got %b want 0", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL id_valid_early: got %b want 0 at E+3", out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_row, out_last, out_data} !== {1'b1, 1'b0, 1'b0, 32'h0200_0100}) begin
            errors++;
            $display("[TB] FAIL id_row0: got v=%b r=%0d l=%b d=%h want v=1 r=0 l=0 d=02000100", out_valid, out_row, out_last, out_data);
        end
        step();
        checks++;
        if ({out_valid, out_row, out_last, out_data} !== {1'b1, 1'b1, 1'b1, 32'h0400_0300}) begin
            errors++;
            $display("[TB] FAIL id_row1: got v=%b r=%0d l=%b d=%h want v=1 r=1 l=1 d=04000300", out_valid, out_row, out_last, out_data);
        end
        step();
        checks++;
        if ({busy, out_valid, overflow, out_data} !== {3'b000, 32'h0}) begin
            errors++;
            $display("[TB] FAIL id_done: got b=%b v=%b o=%b d=%h want 0 0 0 00000000", busy, out_valid, overflow, out_data);
        end
    endtask

    task automatic test_saturation();
        int n;
        out_ready = 1'b1;
        beat_a[0] = 32'h0000_FF00;
        beat_b[0] = 32'h0000_0200;
        begin_job(3'd1);
        feed(1, 1'b0);
        wait_valid(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("[TB] FAIL sat_neg_latency: got %0d want 2", n);
        end
        checks++;
        if (out_data !== 32'h0000_FE00) begin
            errors++;
            $display("[TB] FAIL sat_neg_row0: got %h want 0000fe00", out_data);
        end
        step();
        step();
        checks++;
        if ({busy, overflow} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL sat_neg_ovf: got b=%b o=%b want 0 0", busy, overflow);
        end
        beat_a[0] = 32'h0000_7F00;
        beat_b[0] = 32'h0000_7F00;
        begin_job(3'd1);
        feed(1, 1'b0);
        wait_valid(n);
        checks++;
        if (out_data !== 32'h0000_7FFF) begin
            errors++;
            $display("[TB] FAIL sat_clip_row0: got %h want 00007fff (valid wait %0d)", out_data, n);
        end
        step();
        step();
        checks++;
        if ({busy, overflow} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL sat_clip_ovf: got b=%b o=%b want 0 1", busy, overflow);
        end
    endtask

    task automatic test_k_zero();
        out_ready = 1'b1;
        begin_job(3'd0);
        checks++;
        if ({busy, in_ready, out_valid, overflow, out_row, out_data} !== {4'b1010, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL k0_row0: got b=%b r=%b v=%b o=%b row=%0d d=%h want 1 0 1 0 0 00000000", busy, in_ready, out_valid, overflow, out_row, out_data);
        end
        step();
        checks++;
        if ({out_valid, out_row, out_last, out_data} !== {3'b111, 32'h0}) begin
            errors++;
            $display("[TB] FAIL k0_row1: got v=%b r=%0d l=%b d=%h want 1 1 1 00000000", out_valid, out_row, out_last, out_data);
        end
        step();
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL k0_done: got b=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_stall();
        int n;
        set_identity();
        out_ready = 1'b1;
        begin_job(3'd2);
        feed(2, 1'b1);
        wait_valid(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("[TB] FAIL stall_latency: got %0d want 2", n);
        end
        checks++;
        if ({out_row, out_last, out_data} !== {2'b00, 32'h0200_0100}) begin
            errors++;
            $display("[TB] FAIL stall_row0: got r=%0d l=%b d=%h want 0 0 02000100", out_row, out_last, out_data);
        end
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, out_row, out_last, out_data} !== {3'b111, 32'h0400_0300}) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got v=%b r=%0d l=%b d=%h want 1 1 1 04000300", i, out_valid, out_row, out_last, out_data);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stall_done: got b=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        set_identity();
        out_ready = 1'b1;
        begin_job(3'd2);
        start = 1'b1; k_len = 3'd1;
        in_valid = 1'b1; in_a = beat_a[0]; in_b = beat_b[0];
        step();
        start = 1'b0;
        in_a = beat_a[1]; in_b = beat_b[1];
        step();
        in_valid = 1'b0; in_a = '0; in_b = '0;
        wait_valid(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("[TB] FAIL busy_latency: got %0d want 2", n);
        end
        start = 1'b1; k_len = 3'd0;
        checks++;
        if (out_data !== 32'h0200_0100) begin
            errors++;
            $display("[TB] FAIL busy_row0: got %h want 02000100", out_data);
        end
        step();
        checks++;
        if ({out_row, out_data} !== {1'b1, 32'h0400_0300}) begin
            errors++;
            $display("[TB] FAIL busy_row1: got r=%0d d=%h want 1 04000300", out_row, out_data);
        end
        start = 1'b0;
        step();
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL busy_done: got b=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_kmax_clamp();
        int beats;
        out_ready = 1'b0;
        begin_job(3'd7);
        in_valid = 1'b1;
        in_a = 32'h0100_0100;
        in_b = 32'h0100_0100;
        beats = 0;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) beats++;
            step();
        end
        in_valid = 1'b0; in_a = '0; in_b = '0;
        checks++;
        if (beats !== 4) begin
            errors++;
            $display("[TB] FAIL kmax_beats: got %0d want 4", beats);
        end
        checks++;
        if ({out_valid, out_row, out_data} !== {2'b10, 32'h0400_0400}) begin
            errors++;
            $display("[TB] FAIL kmax_row0: got v=%b r=%0d d=%h want 1 0 04000400", out_valid, out_row, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_row, out_last, out_data} !== {2'b11, 32'h0400_0400}) begin
            errors++;
            $display("[TB] FAIL kmax_row1: got r=%0d l=%b d=%h want 1 1 04000400", out_row, out_last, out_data);
        end
        step();
    endtask

    task automatic test_reset_mid_flush();
        int n;
        set_identity();
        out_ready = 1'b1;
        begin_job(3'd2);
        feed(2, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, out_valid, out_last, overflow, out_row, out_data} !== {6'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL rst_abort: got b=%b r=%b v=%b l=%b o=%b row=%0d d=%h want all zero", busy, in_ready, out_valid, out_last, overflow, out_row, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        begin_job(3'd2);
        feed(2, 1'b0);
        wait_valid(n);
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h0200_0100} || n !== 2) begin
            errors++;
            $display("[TB] FAIL rst_rerun_row0: got v=%b d=%h wait=%0d want 1 02000100 2", out_valid, out_data, n);
        end
        step();
        checks++;
        if (out_data !== 32'h0400_0300) begin
            errors++;
            $display("[TB] FAIL rst_rerun_row1: got %h want 04000300", out_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturation();
        test_k_zero();
        test_stall();
        test_start_while_busy();
        test_kmax_clamp();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
